// File: rtl/phy_rx_sync_ctrl_pkg.sv
// Shared constants for the PHY receive synchronization path: FSM encoding and
// the link-layer control bytes, so transmit-side blocks use the same values.
package phy_rx_sync_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE_ST = 2'd0,
    INIT    = 2'd1,
    ACTIVE  = 2'd2,
    LOST    = 2'd3
  } sync_state_e;

  localparam logic [7:0] COMMA_BYTE     = 8'hBC;
  localparam logic [7:0] IDLE_BYTE      = 8'h7C;
  localparam int         DEF_LOCK_COUNT = 4;
  localparam int         DEF_GAP_MAX    = 16;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/phy_rx_byte_classify.sv
// Combinational decode of a received byte into comma / idle-filler / payload.
module phy_rx_byte_classify
  import phy_rx_sync_ctrl_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_BYTE,
  parameter logic [7:0] IDLE  = IDLE_BYTE
) (
  input  logic [7:0] data_in,
  output logic       is_comma,
  output logic       is_idle,
  output logic       is_payload
);

  assign is_comma   = (data_in == COMMA);
  assign is_idle    = (data_in == IDLE);
  assign is_payload = !is_comma && !is_idle;

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Receive-link sync controller: acquires lock on a run of COMMA bytes, forwards
// payload while aligned, and detects/counts loss of lock.
module phy_rx_sync_ctrl
  import phy_rx_sync_ctrl_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_BYTE,
  parameter logic [7:0] IDLE       = IDLE_BYTE,
  parameter int         LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int         GAP_MAX    = DEF_GAP_MAX
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic [1:0] state,
  output logic       lock_lost,
  output logic [7:0] loss_cnt
);

  localparam logic [3:0] LOCK_CNT_B = 4'(LOCK_COUNT);
  localparam logic [3:0] LOCK_M1_B  = 4'(LOCK_COUNT - 1);
  localparam logic [7:0] GAP_MAX_B  = 8'(GAP_MAX);

  logic is_comma, is_idle, is_payload;

  phy_rx_byte_classify #(
    .COMMA (COMMA),
    .IDLE  (IDLE)
  ) u_classify (
    .data_in    (data_in),
    .is_comma   (is_comma),
    .is_idle    (is_idle),
    .is_payload (is_payload)
  );

  sync_state_e state_q, state_d;
  logic [3:0]  comma_cnt_q, comma_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        active_q, active_d;
  logic        lock_lost_q, lock_lost_d;
  logic [7:0]  loss_cnt_q, loss_cnt_d;
  logic [7:0]  gap_inc;

  assign gap_inc = gap_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    lock_lost_d = 1'b0;
    loss_cnt_d  = loss_cnt_q;

    if (!enable) begin
      state_d     = IDLE_ST;
      comma_cnt_d = 4'd0;
      gap_cnt_d   = 8'd0;
    end else begin
      case (state_q)
        IDLE_ST: begin
          state_d     = INIT;
          comma_cnt_d = 4'd0;
          gap_cnt_d   = 8'd0;
        end
        INIT: begin
          if (is_comma) begin
            if (comma_cnt_q >= LOCK_M1_B) begin
              state_d     = ACTIVE;
              comma_cnt_d = LOCK_CNT_B;
              gap_cnt_d   = 8'd0;
            end else begin
              comma_cnt_d = comma_cnt_q + 4'd1;
            end
          end else begin
            comma_cnt_d = 4'd0;
          end
        end
        ACTIVE: begin
          if (is_comma) begin
            gap_cnt_d = 8'd0;
          end else if (is_idle || is_payload) begin
            // The byte that would complete the gap is dropped, not forwarded.
            if (gap_inc == GAP_MAX_B) begin
              state_d = LOST;
            end else begin
              gap_cnt_d = gap_inc;
              if (is_payload) begin
                data_d  = data_in;
                valid_d = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d     = INIT;
          comma_cnt_d = 4'd0;
          gap_cnt_d   = 8'd0;
        end
      endcase
    end

    if (state_d == LOST) begin
      lock_lost_d = 1'b1;
      comma_cnt_d = 4'd0;
      loss_cnt_d  = sat_inc8(loss_cnt_q);
    end

    active_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE_ST;
      comma_cnt_q <= 4'd0;
      gap_cnt_q   <= 8'd0;
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
      lock_lost_q <= lock_lost_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;
  assign state     = state_q;
  assign lock_lost = lock_lost_q;
  assign loss_cnt  = loss_cnt_q;

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Scoreboard bench for phy_rx_sync_ctrl: directed scenarios plus randomized
// byte streams checked against a behavioural link model.
module tb_phy_rx_sync_ctrl;

  localparam int LOCK = 4;
  localparam int GAP  = 16;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic [1:0] state;
  logic       lock_lost;
  logic [7:0] loss_cnt;

  phy_rx_sync_ctrl #(
    .LOCK_COUNT (LOCK),
    .GAP_MAX    (GAP)
  ) dut (
    .clk_4f    (clk_4f),
    .reset     (reset),
    .enable    (enable),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .state     (state),
    .lock_lost (lock_lost),
    .loss_cnt  (loss_cnt)
  );

  always #5 clk_4f = ~clk_4f;

  typedef struct {
    logic [1:0] st;
    bit         act;
    bit         vld;
    logic [7:0] dout;
    bit         ll;
    logic [7:0] lc;
  } exp_t;

  exp_t       sq[$];
  logic [7:0] dq[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Link model: 0 = disabled, 1 = hunting for commas, 2 = locked, 3 = just lost lock
  int         m_mode, m_commas, m_gap, m_losses;
  logic [7:0] m_data;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_commas = 0; m_gap = 0; m_losses = 0; m_data = 8'h00;
  endtask

  task automatic model(input bit en, input logic [7:0] b, output exp_t e);
    bit fwd;
    bit lost_now;
    fwd = 0;
    lost_now = 0;
    if (!en) begin
      m_mode = 0; m_commas = 0; m_gap = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_commas = 0; m_gap = 0;
    end else if (m_mode == 3) begin
      m_mode = 1; m_commas = 0;
    end else if (m_mode == 1) begin
      if (b == 8'hBC) begin
        m_commas++;
        if (m_commas == LOCK) begin
          m_mode = 2; m_gap = 0;
        end
      end else begin
        m_commas = 0;
      end
    end else begin
      if (b == 8'hBC) begin
        m_gap = 0;
      end else begin
        m_gap++;
        if (m_gap == GAP) begin
          m_mode = 3;
          lost_now = 1;
          m_losses = (m_losses < 255) ? m_losses + 1 : 255;
        end else if (b != 8'h7C) begin
          fwd = 1;
          m_data = b;
        end
      end
    end
    e.st   = 2'(m_mode);
    e.act  = (m_mode == 2);
    e.vld  = fwd;
    e.dout = m_data;
    e.ll   = lost_now;
    e.lc   = 8'(m_losses);
  endtask

  task automatic step(input bit en, input logic [7:0] b);
    exp_t e;
    enable  = en;
    data_in = b;
    model(en, b, e);
    @(posedge clk_4f);
    #1;
    cycle++;
    sq.push_back(e);
    if (e.vld) dq.push_back(e.dout);
  endtask

  function automatic logic [7:0] rand_pay();
    logic [7:0] v;
    do v = 8'($urandom_range(0, 255)); while (v == 8'hBC || v == 8'h7C);
    return v;
  endfunction

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 8'hBC);
  endtask

  // Monitor: one status entry per clock; one payload entry per valid_out beat.
  always @(negedge clk_4f) begin
    exp_t e;
    logic [7:0] d;
    if (sq.size() > 0) begin
      e = sq.pop_front();
      chk("state", int'(state), int'(e.st));
      chk("active", int'(active), int'(e.act));
      chk("valid_out", int'(valid_out), int'(e.vld));
      chk("data_out", int'(data_out), int'(e.dout));
      chk("lock_lost", int'(lock_lost), int'(e.ll));
      chk("loss_cnt", int'(loss_cnt), int'(e.lc));
      if (valid_out) begin
        if (dq.size() == 0) begin
          chk("payload_unexpected", 1, 0);
        end else begin
          d = dq.pop_front();
          chk("payload", int'(data_out), int'(d));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_active"}, int'(active), 0);
    chk({tag, "_valid"}, int'(valid_out), 0);
    chk({tag, "_data"}, int'(data_out), 0);
    chk({tag, "_lock_lost"}, int'(lock_lost), 0);
    chk({tag, "_loss_cnt"}, int'(loss_cnt), 0);
  endtask

  initial begin
    int seg_len, comma_w, r;
    reset   = 1'b1;
    enable  = 1'b0;
    data_in = 8'h00;
    model_reset();
    repeat (3) @(posedge clk_4f);
    #2;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk_4f);
    #1;

    // Lock acquisition from idle
    step(1'b1, 8'h00);
    send_commas(LOCK);
    // Payload forwarding with an idle filler in between
    step(1'b1, 8'h11); step(1'b1, 8'h22); step(1'b1, 8'h7C); step(1'b1, 8'h33);
    // An interrupted comma run must restart the count
    step(1'b0, 8'h00); step(1'b1, 8'h00);
    send_commas(3); step(1'b1, 8'h55); send_commas(LOCK);
    // Gap overflow: GAP payload bytes with no comma
    for (int i = 0; i < GAP; i++) step(1'b1, rand_pay());
    step(1'b1, 8'h00);
    // Enable drop while locked, then relock
    send_commas(LOCK);
    step(1'b0, 8'hBC); step(1'b1, 8'h00);
    send_commas(LOCK - 1); step(1'b1, 8'h44); send_commas(LOCK);

    // Randomized segments with varying comma density
    for (int s = 0; s < 120; s++) begin
      seg_len = $urandom_range(5, 40);
      comma_w = $urandom_range(0, 3) * 2;
      for (int i = 0; i < seg_len; i++) begin
        r = $urandom_range(0, 9);
        step(($urandom_range(0, 59) != 0),
             (r < comma_w) ? 8'hBC : (r == 9) ? 8'h7C : rand_pay());
      end
    end

    // Asynchronous reset between edges while payload is flowing
    step(1'b1, 8'h00);
    send_commas(LOCK + 1);
    for (int i = 0; i < GAP; i++) step(1'b1, rand_pay());
    send_commas(LOCK);
    for (int i = 0; i < 3; i++) step(1'b1, rand_pay());
    @(negedge clk_4f);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    model_reset();
    dq.delete();
    @(posedge clk_4f);
    #3;
    reset = 1'b0;
    @(posedge clk_4f);
    #1;

    // Saturation of the loss counter
    for (int n = 0; n < 258; n++) begin
      step(1'b1, 8'h00);
      send_commas(LOCK);
      for (int i = 0; i < GAP; i++) step(1'b1, (i % 5 == 2) ? 8'h7C : rand_pay());
    end
    @(negedge clk_4f);
    #1;
    chk("loss_cnt_saturated", int'(loss_cnt), 255);
    chk("status_queue_drained", sq.size(), 0);
    chk("payload_queue_drained", dq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
